// File: rtl/t09_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Imported by the debouncer top and any block that reuses its state encoding.
package t09_debounce_pkg;

  localparam int DB_CYCLES_DEFAULT = 100000;

  typedef enum logic [1:0] {
    ST_IDLE            = 2'd0,
    ST_CONFIRM_PRESS   = 2'd1,
    ST_HELD            = 2'd2,
    ST_CONFIRM_RELEASE = 2'd3
  } db_state_t;

endpackage

// File: rtl/t09_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Clears to zero on a synchronous active-high reset.
module t09_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], in};
    end
  end

  assign out = r_sync[STAGES-1];

endmodule

// File: rtl/t09_button_debounce.sv
// Synchronizes and debounces a raw push-button input.
// Emits one registered pulse per accepted press and the debounced level.
module t09_button_debounce
  import t09_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic button_i,
  output logic pulse,
  output logic level
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};

  logic      w_synced;
  db_state_t r_state;
  db_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic      r_pulse;
  logic      r_level;
  logic      w_pulse_nxt;
  logic      w_level_nxt;

  t09_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .in  (button_i),
    .out (w_synced)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_synced) begin
          w_state_nxt = ST_CONFIRM_PRESS;
          w_cnt_nxt   = C_ONE;
        end
      end
      ST_CONFIRM_PRESS: begin
        if (!w_synced) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_LAST) begin
          w_state_nxt = ST_HELD;
        end else if (r_cnt != C_MAX) begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      ST_HELD: begin
        if (!w_synced) begin
          w_state_nxt = ST_CONFIRM_RELEASE;
          w_cnt_nxt   = C_ONE;
        end
      end
      ST_CONFIRM_RELEASE: begin
        if (w_synced) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_LAST) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt != C_MAX) begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Only the press-confirmation edge strobes; release is silent.
  assign w_pulse_nxt = (r_state == ST_CONFIRM_PRESS) &&
                       (w_state_nxt == ST_HELD);
  assign w_level_nxt = (w_state_nxt == ST_HELD) ||
                       (w_state_nxt == ST_CONFIRM_RELEASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
    end
  end

  assign pulse = r_pulse;
  assign level = r_level;

endmodule

// File: tb/tb_t09_button_debounce.sv
// Directed self-checking bench for the button debouncer.
// Runs with SYNC_STAGES=2, DB_CYCLES=4 (press/release latency 5 edges).
module tb_t09_button_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_i = 1'b0;
  logic pulse;
  logic level;

  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;

  t09_button_debounce #(
    .SYNC_STAGES(2),
    .DB_CYCLES  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .button_i (button_i),
    .pulse    (pulse),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one edge, check outputs just after it.
  task automatic cyc(input logic r, input logic b,
                     input logic ep, input logic el,
                     input string tag, input int idx);
    rst = r;
    button_i = b;
    @(posedge clk);
    #1;
    chk($sformatf("%s[%0d].pulse", tag, idx), int'(pulse), int'(ep));
    chk($sformatf("%s[%0d].level", tag, idx), int'(level), int'(el));
    if (pulse === 1'b1) n_pulse++;
  endtask

  // Button held high from an idle state: outputs rise at edge index 5.
  task automatic press(input string tag, input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b1, i == 5, i >= 5, tag, i);
  endtask

  // Button released from a held state: level falls at edge index 5.
  task automatic release_btn(input string tag, input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 1'b0, i < 5, tag, i);
  endtask

  logic [7:0] bounce_pat;
  int p0;

  initial begin
    // Reset, with button briefly high to show reset dominates.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, i[0], 1'b0, 1'b0, "reset", i);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle", i);

    // Clean press, 20 cycles held, then release.
    press("clean_press", 20);
    release_btn("clean_rel", 10);

    // Bounce: 1,1,0,0,1,1,0,0 then stable high.
    bounce_pat = 8'b0011_0011;
    for (int i = 0; i < 8; i++)
      cyc(1'b0, bounce_pat[i], 1'b0, 1'b0, "bounce", i);
    press("bounce_settle", 16);

    // Glitches while held: 2-cycle low, then 3-cycle low.
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "glitch2", i);
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, "glitch2_hi", i);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "glitch3", i);
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, "glitch3_hi", i);
    release_btn("glitch_rel", 10);

    // Reset at E+3 while held; fresh press counted from F=E+4.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_pre", i);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "rst_mid", 0);
    press("rst_mid_post", 12);
    release_btn("rst_mid_rel", 10);

    // Long hold: exactly one pulse over 100 cycles.
    p0 = n_pulse;
    press("long_hold", 100);
    chk("long_hold.npulse", n_pulse - p0, 1);
    release_btn("long_rel", 10);

    // Three clean presses: one pulse each, none on release.
    p0 = n_pulse;
    for (int k = 0; k < 3; k++) begin
      press($sformatf("multi%0d", k), 10);
      release_btn($sformatf("multi%0d_rel", k), 10);
    end
    chk("multi.npulse", n_pulse - p0, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/t09_button_debounce.md
# t09_button_debounce

Upstream conditioning stage for the mode-cycling FSM. It takes a raw, asynchronous, bouncing push-button input and synchronizes and debounces it. On each confirmed press it emits exactly one single-cycle `pulse`, which drives the mode FSM's `signal` input directly. It also exports the debounced button `level` for status use.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count; legal values are 2 or more.
- `DB_CYCLES`, default 100000: number of consecutive equal synchronized samples needed to accept a level change; legal values are 2 or more.

Ports:
- `clk`  in  1  System clock. This block has one clock and a synchronous, active-high reset.
- `rst`  in  1  Synchronous, active-high reset.
- `button_i`  in  1  Raw button input. It is asynchronous and may bounce.
- `pulse`  out  1  Registered, one-cycle-high strobe on each accepted press (0→1 transition only).
- `level`  out  1  Registered debounced button state.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops on `button_i`. The last stage is `synced`.
- Counter: `cnt`, width $clog2(DB_CYCLES+1), unsigned. It saturates and never wraps.

The FSM has 4 states:
- IDLE (`level`=0):
  - If `synced`=1, go to CONFIRM_PRESS and load `cnt`=1.
  - Otherwise stay in IDLE.
- CONFIRM_PRESS (`level`=0):
  - If `synced`=0, return to IDLE. This is a bounce: no pulse.
  - If `synced`=1 and `cnt`==DB_CYCLES-1, go to HELD and register `pulse`=1 and `level`=1.
  - Otherwise increment `cnt`.
- HELD (`level`=1):
  - If `synced`=0, go to CONFIRM_RELEASE and load `cnt`=1.
- CONFIRM_RELEASE (`level`=1):
  - If `synced`=1, return to HELD. No pulse.
  - If `synced`=0 and `cnt`==DB_CYCLES-1, go to IDLE and register `level`=0.
  - Otherwise increment `cnt`.

Output rules:
- `pulse` is 1 only in the cycle immediately after the CONFIRM_PRESS→HELD edge, then returns to 0.
- `pulse` is never high on 2 consecutive cycles.
- A press held indefinitely produces exactly one pulse.
- A release never produces a pulse.

## Timing
Reset:
- On any edge with `rst`=1, clear all state: sync chain = 0, state = IDLE, `cnt` = 0, `pulse` = 0, `level` = 0.
- Reset dominates all other inputs.
- Reset during CONFIRM_PRESS aborts that press with no pulse.
- If the button is still held after reset, it is treated as a fresh press and gets the full latency from the first edge with `rst`=0.

Press latency:
- Let E be the first edge at which `button_i`=1 is captured, after which the input stays stable.
- `pulse` and `level` rise at edge E+SYNC_STAGES+DB_CYCLES-1.
- With SYNC_STAGES=2 and DB_CYCLES=4, this is E+5.

Release latency:
- The same formula applies to the fall of `level`. No `pulse` is generated.

Bounce and glitch rejection:
- Any opposite sample during confirmation returns the FSM to its prior stable state.
- The count restarts on the next qualifying sample.
- Glitches shorter than DB_CYCLES synchronized cycles are invisible at the outputs.

Other:
- Minimum spacing between two pulses is 2·DB_CYCLES cycles.
- There is no combinational path from input to output.

## Structure
Package `t09_debounce_pkg`:
- State typedef, 2-bit: IDLE=0, CONFIRM_PRESS=1, HELD=2, CONFIRM_RELEASE=3.
- A shared default-DB_CYCLES constant.

Sub-module `t09_synchronizer`:
- Parameter `STAGES`.
- Ports: clk, rst, in, out.
- Reused for other asynchronous inputs.

The top level holds the FSM, counter and output registers.

## Test plan
All scenarios use DB_CYCLES=4 and SYNC_STAGES=2.
- Clean press: `button_i` 0→1 captured at E and held 20 cycles → `pulse`=1 for exactly the cycle after E+5, `level`=1 from E+5. Release captured at R → `level`=0 at R+5, `pulse` stays 0.
- Bounce: `button_i` toggles 1,1,0,0,1,1,0,0 and is then stable 1 from edge S → no pulse during the toggling, exactly one pulse at S+5.
- Glitch while held: in HELD, drive `button_i`=0 for 2 cycles → `level` remains 1, no pulse. A subsequent 3-cycle low also gets no release.
- Reset mid-confirm: `rst`=1 at E+3 for one cycle while the button is held → outputs are 0 and there is no pulse near E+5. One pulse arrives at F+5, where F is the first edge with `rst`=0.
- Long hold: button held 100 cycles → exactly one pulse.
- Integration: 3 clean presses into `t09_fsm_mode.signal` → mode sequence 1→2→0→1, one step per press.
